vram_rect_writer: RTL and testbench
===================================

// Module: vram_rect_writer
// PURPOSE
//  Drawing engine on the VRAM write side. It accepts rectangle-fill and clear-screen
//  commands and writes 12-bit RGB pixels into the 15-bit-address frame buffer, one
//  pixel per clock. It drives the write port of the dual-port VRAM; the display
//  pipeline reads the other port in the same pclk domain.
// PARAMETERS
//  H_RES   200  frame width in pixels (row stride of VRAM)
//  V_RES   150  frame height in pixels; H_RES*V_RES must be <= 2**ADDR_W
//  ADDR_W  15   VRAM address width
//  DATA_W  12   pixel width, {R[3:0],G[3:0],B[3:0]}
// PORTS
//  pclk       in   1       pixel/system clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       engine idle, command accepted when valid&ready
//  cmd_clear  in   1       1: fill the whole frame, ignore x/y/w/h
//  cmd_x      in   8       left column
//  cmd_y      in   8       top row
//  cmd_w      in   8       width in pixels
//  cmd_h      in   8       height in pixels
//  cmd_color  in   DATA_W  fill colour
//  we         out  1       VRAM write enable (registered)
//  waddr      out  ADDR_W  VRAM write address (registered)
//  wdata      out  DATA_W  VRAM write data (registered)
//  busy       out  1       high from the accept cycle+1 until done
//  done       out  1       one-cycle pulse after the last write, or after a rejected/empty command
// BEHAVIOUR
//  - Reset values: cmd_ready=1, we=0, waddr=0, wdata=0, busy=0, done=0, FSM=IDLE.
//  - FSM: IDLE -> SETUP -> FILL -> DONE -> IDLE. cmd_ready=1 only in IDLE.
//    Command fields are latched on the accept edge. Inputs are ignored outside IDLE.
//  - Clear command: it is treated as x=0, y=0, w=H_RES, h=V_RES.
//  - SETUP (1 cycle): clipping and base address.
//    - If x>=H_RES, y>=V_RES, w==0 or h==0: go to DONE with no writes.
//    - Otherwise: x_end=min(x+w,H_RES) and y_end=min(y+h,V_RES), computed 9 bits wide
//      with no wrap. row_base=y*H_RES, constant multiply at ADDR_W bits. col=x.
//  - FILL: one write per cycle, row-major.
//    - we=1, waddr=row_base+col, wdata=color.
//    - When col+1==x_end: col<=x, row_base<=row_base+H_RES, row++.
//    - Last write is (x_end-1, y_end-1), then DONE.
//  - DONE (1 cycle): done=1, we=0. Then IDLE, with cmd_ready=1 on the following cycle.
//  - Latency: accept at edge N; first we=1 visible after edge N+2.
//    Write count = (x_end-x)*(y_end-y). done is high the cycle after the last we.
//  - No multiplier in FILL; addresses are incremental adds only. waddr never
//    exceeds H_RES*V_RES-1.
//  - rst during FILL aborts the command at the next edge: we=0, busy=0, IDLE.
//    Pixels already written stay in VRAM.
//  - cmd_valid held high across DONE: the next command is accepted in the first
//    IDLE cycle (no extra gap beyond IDLE).
// STRUCTURE
//  - Shared package vga_pkg: H_RES/V_RES/ADDR_W/DATA_W defaults, FSM state
//    encoding (IDLE, SETUP, FILL, DONE), and a 12-bit colour constant set
//    (BLACK=12'h000, WHITE=12'hFFF, RED=12'hF00).
//  - Single flat module with a 4-state FSM and a col/row/row_base datapath.
//  - Optional sub-module rect_clip: combinational x_end/y_end/empty computation
//    used in SETUP.
// TESTING
//  1. Fill (3,4), w=2, h=2, colour 12'hF00 -> writes to 803,804,1003,1004 on 4
//     consecutive cycles; done 1 cycle later; busy low after done.
//  2. Edge clip (198,149), w=5, h=3 -> exactly 2 writes, to 29998 and 29999; done follows.
//  3. w=0 (also x=200) -> no we pulse; done 2 cycles after accept; cmd_ready back high.
//  4. cmd_clear with colour 12'h000 -> 30000 writes to 0..29999, each address once,
//     in order; done at cycle accept+30002.
//  5. rst high mid-FILL of a 10x10 fill -> we=0 and cmd_ready=1 after that edge;
//     a new 1x1 command then writes its single pixel correctly.
//  6. Two commands back-to-back with cmd_valid held -> second accepted in the first
//     IDLE cycle after done; no writes overlap and cmd_ready is never high while busy.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, drawing-engine state encoding and colour constants.
package vga_pkg;

   localparam int H_RES  = 200;
   localparam int V_RES  = 150;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_FILL,
      S_DONE
   } state_t;

   localparam logic [11:0] BLACK = 12'h000;
   localparam logic [11:0] WHITE = 12'hFFF;
   localparam logic [11:0] RED   = 12'hF00;

endpackage

// File: rtl/rect_clip.sv
// Combinational clipping of a rectangle against the frame: exclusive end column/row
// (9 bits, no wrap) and an empty flag for off-screen or zero-sized rectangles.
module rect_clip #(
   parameter int H_RES = vga_pkg::H_RES,
   parameter int V_RES = vga_pkg::V_RES
) (
   input  logic [7:0] i_x,
   input  logic [7:0] i_y,
   input  logic [7:0] i_w,
   input  logic [7:0] i_h,
   output logic [8:0] o_x_end,
   output logic [8:0] o_y_end,
   output logic       o_empty
);

   localparam logic [8:0] L_H = 9'(H_RES);
   localparam logic [8:0] L_V = 9'(V_RES);

   logic [8:0] w_xs;
   logic [8:0] w_ys;

   assign w_xs    = {1'b0, i_x} + {1'b0, i_w};
   assign w_ys    = {1'b0, i_y} + {1'b0, i_h};
   assign o_x_end = (w_xs > L_H) ? L_H : w_xs;
   assign o_y_end = (w_ys > L_V) ? L_V : w_ys;
   assign o_empty = ({1'b0, i_x} >= L_H) || ({1'b0, i_y} >= L_V) ||
                    (i_w == '0) || (i_h == '0);

endmodule

// File: rtl/vram_rect_writer.sv
// Rectangle-fill / clear-screen engine driving the VRAM write port, one pixel per clock,
// row-major, with incremental address generation only.
module vram_rect_writer
   import vga_pkg::*;
#(
   parameter int H_RES  = vga_pkg::H_RES,
   parameter int V_RES  = vga_pkg::V_RES,
   parameter int ADDR_W = vga_pkg::ADDR_W,
   parameter int DATA_W = vga_pkg::DATA_W
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_clear,
   input  logic [7:0]        cmd_x,
   input  logic [7:0]        cmd_y,
   input  logic [7:0]        cmd_w,
   input  logic [7:0]        cmd_h,
   input  logic [DATA_W-1:0] cmd_color,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done
);

   state_t              r_state, w_state_nxt;
   logic [7:0]          r_x, r_y, r_w, r_h;
   logic [DATA_W-1:0]   r_color;
   logic [7:0]          r_col, r_row;
   logic [ADDR_W-1:0]   r_row_base;
   logic [8:0]          r_x_end, r_y_end;
   logic                r_we, r_done;
   logic [ADDR_W-1:0]   r_waddr;
   logic [DATA_W-1:0]   r_wdata;

   logic [8:0]          w_x_end, w_y_end;
   logic                w_empty, w_accept, w_row_wrap, w_last;
   logic                w_we_nxt, w_done_nxt;
   logic [ADDR_W-1:0]   w_row_base0;

   rect_clip #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_clip (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_w     (r_w),
      .i_h     (r_h),
      .o_x_end (w_x_end),
      .o_y_end (w_y_end),
      .o_empty (w_empty)
   );

   assign w_accept    = cmd_valid && (r_state == S_IDLE);
   assign w_row_base0 = ADDR_W'(r_y) * ADDR_W'(H_RES);
   assign w_row_wrap  = (({1'b0, r_col} + 9'd1) == r_x_end);
   assign w_last      = w_row_wrap && (({1'b0, r_row} + 9'd1) == r_y_end);

   always_ff @(posedge pclk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (cmd_valid) w_state_nxt = S_SETUP;
         S_SETUP: w_state_nxt = w_empty ? S_DONE : S_FILL;
         S_FILL:  if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready  = (r_state == S_IDLE);
      busy       = (r_state != S_IDLE);
      w_we_nxt   = (r_state == S_FILL);
      w_done_nxt = (r_state == S_DONE);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_x <= '0; r_y <= '0; r_w <= '0; r_h <= '0;
         r_color    <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
         r_x_end    <= '0;
         r_y_end    <= '0;
         r_we       <= 1'b0;
         r_done     <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= DATA_W'(BLACK);
      end else begin
         r_we   <= w_we_nxt;
         r_done <= w_done_nxt;
         if (w_accept) begin
            // A clear is just a full-frame rectangle through the same path.
            r_x     <= cmd_clear ? '0 : cmd_x;
            r_y     <= cmd_clear ? '0 : cmd_y;
            r_w     <= cmd_clear ? 8'(H_RES) : cmd_w;
            r_h     <= cmd_clear ? 8'(V_RES) : cmd_h;
            r_color <= cmd_color;
         end
         if (r_state == S_SETUP) begin
            r_col      <= r_x;
            r_row      <= r_y;
            r_row_base <= w_row_base0;
            r_x_end    <= w_x_end;
            r_y_end    <= w_y_end;
         end
         if (r_state == S_FILL) begin
            r_waddr <= r_row_base + ADDR_W'(r_col);
            r_wdata <= r_color;
            if (w_row_wrap) begin
               r_col      <= r_x;
               r_row      <= r_row + 8'd1;
               r_row_base <= r_row_base + ADDR_W'(H_RES);
            end else begin
               r_col <= r_col + 8'd1;
            end
         end
      end
   end

   assign we    = r_we;
   assign waddr = r_waddr;
   assign wdata = r_wdata;
   assign done  = r_done;

endmodule

// File: tb/tb_vram_rect_writer.sv
// Self-checking bench: directed vector table, reset abort, back-to-back handshake and
// random rectangles checked against a pixel-list reference model.
module tb_vram_rect_writer;
   import vga_pkg::*;

   logic              pclk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_clear;
   logic [7:0]        cmd_x, cmd_y, cmd_w, cmd_h;
   logic [DATA_W-1:0] cmd_color;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_err    = 0;

   always #5 pclk = ~pclk;

   vram_rect_writer #(
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .pclk      (pclk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_clear (cmd_clear),
      .cmd_x     (cmd_x),
      .cmd_y     (cmd_y),
      .cmd_w     (cmd_w),
      .cmd_h     (cmd_h),
      .cmd_color (cmd_color),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done)
   );

   typedef struct {
      string       name;
      logic        clr;
      int          x, y, w, h;
      logic [11:0] col;
      int          cnt, first, last;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Reference: list every pixel of the clipped rectangle, row-major.
   task automatic model(input logic clr, input int x, y, w, h, output int q[$]);
      int xs, ys, xe, ye;
      q.delete();
      xs = clr ? 0 : x;
      ys = clr ? 0 : y;
      xe = clr ? H_RES : ((x + w > H_RES) ? H_RES : x + w);
      ye = clr ? V_RES : ((y + h > V_RES) ? V_RES : y + h);
      for (int yy = ys; yy < ye; yy++)
         for (int xx = xs; xx < xe; xx++)
            q.push_back(yy * H_RES + xx);
   endtask

   task automatic run_cmd(input string name, input logic clr, input int x, y, w, h,
                          input logic [11:0] col, output int cnt, first, last);
      int  exp_q[$];
      int  bad;
      bit  seen;
      model(clr, x, y, w, h, exp_q);
      for (int i = 0; i < 50 && !cmd_ready; i++) step();
      check({name, " ready"}, cmd_ready, 1);
      cmd_clear = clr;
      cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 8'(w); cmd_h = 8'(h);
      cmd_color = col;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      cnt = 0; first = -1; last = -1; bad = 0; seen = 0;
      for (int k = 1; k <= exp_q.size() + 20 && !seen; k++) begin
         step();
         if (cmd_ready && busy) bad++;
         if (we) begin
            if (cnt == 0) begin
               first = int'(waddr);
               if (k != 2) bad++;
            end
            if (cnt >= exp_q.size() || int'(waddr) != exp_q[cnt] || wdata !== col) bad++;
            last = int'(waddr);
            cnt++;
         end
         if (done) begin
            seen = 1;
            check({name, " done_latency"}, k, 2 + exp_q.size());
         end
      end
      check({name, " done_seen"}, seen, 1);
      check({name, " write_count"}, cnt, exp_q.size());
      check({name, " stream_errors"}, bad, 0);
   endtask

   initial begin
      vec_t vecs[5];
      int   cnt, first, last;
      int   bad, n_done, k_second;
      int   done_t[$];
      int   got_a[$];
      logic [11:0] got_d[$];
      int   exp_a[$];
      logic [11:0] exp_d[$];

      vecs[0] = '{"fill_3_4",   1'b0,   3,   4, 2, 2, RED,     4,   803,  1004};
      vecs[1] = '{"edge_clip",  1'b0, 198, 149, 5, 3, WHITE,   2, 29998, 29999};
      vecs[2] = '{"w_zero",     1'b0,  10,  10, 0, 5, WHITE,   0,    -1,    -1};
      vecs[3] = '{"x_off",      1'b0, 200,  10, 4, 4, RED,     0,    -1,    -1};
      vecs[4] = '{"clear",      1'b1,  77,  33, 9, 9, BLACK, 30000,   0, 29999};

      rst = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0;
      cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
      repeat (3) step();
      check("rst cmd_ready", cmd_ready, 1);
      check("rst we", we, 0);
      check("rst waddr", waddr, 0);
      check("rst wdata", wdata, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) begin
         run_cmd(vecs[i].name, vecs[i].clr, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                 vecs[i].col, cnt, first, last);
         check({vecs[i].name, " cnt"}, cnt, vecs[i].cnt);
         check({vecs[i].name, " first"}, first, vecs[i].first);
         check({vecs[i].name, " last"}, last, vecs[i].last);
         step();
         check({vecs[i].name, " idle_after"}, cmd_ready && !busy, 1);
      end

      // Reset in the middle of a 10x10 fill.
      cmd_clear = 1'b0; cmd_x = 8'd50; cmd_y = 8'd50; cmd_w = 8'd10; cmd_h = 8'd10;
      cmd_color = RED; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      repeat (6) step();
      check("abort writing", we, 1);
      rst = 1'b1;
      step();
      check("abort we", we, 0);
      check("abort cmd_ready", cmd_ready, 1);
      check("abort busy", busy, 0);
      rst = 1'b0;
      run_cmd("after_abort", 1'b0, 7, 9, 1, 1, WHITE, cnt, first, last);
      check("after_abort addr", first, 1807);

      // Back-to-back with cmd_valid held: second command taken in the first IDLE cycle.
      step();
      cmd_clear = 1'b0; cmd_x = 8'd10; cmd_y = 8'd10; cmd_w = 8'd2; cmd_h = 8'd2;
      cmd_color = RED; cmd_valid = 1'b1;
      step();
      cmd_x = 8'd20; cmd_y = 8'd20; cmd_w = 8'd3; cmd_h = 8'd1; cmd_color = WHITE;
      exp_a = '{2010, 2011, 2210, 2211, 4020, 4021, 4022};
      exp_d = '{RED, RED, RED, RED, WHITE, WHITE, WHITE};
      bad = 0; n_done = 0; k_second = -1;
      for (int k = 1; k <= 40 && n_done < 2; k++) begin
         step();
         if (cmd_ready && busy) bad++;
         if (we) begin
            got_a.push_back(int'(waddr));
            got_d.push_back(wdata);
         end
         if (done) begin
            n_done++;
            done_t.push_back(k);
         end else if (n_done == 1 && cmd_valid) begin
            cmd_valid = 1'b0;
            k_second = busy ? k : -1;
         end
      end
      cmd_valid = 1'b0;
      check("b2b done_count", n_done, 2);
      check("b2b second_accept", k_second, 7);
      check("b2b done1", (done_t.size() > 0) ? done_t[0] : -1, 6);
      check("b2b done2", (done_t.size() > 1) ? done_t[1] : -1, 12);
      check("b2b write_count", got_a.size(), exp_a.size());
      for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
         if (got_a[i] != exp_a[i] || got_d[i] !== exp_d[i]) bad++;
      check("b2b stream_errors", bad, 0);

      // Random rectangles, some partially or fully off-screen.
      for (int i = 0; i < 30; i++) begin
         run_cmd($sformatf("rand%0d", i), 1'b0,
                 int'($urandom_range(0, 210)), int'($urandom_range(0, 160)),
                 int'($urandom_range(0, 40)), int'($urandom_range(0, 20)),
                 12'($urandom), cnt, first, last);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
